// File: rtl/pio_fifo_hub.sv
// Per-machine TX (host->machine) and RX (machine->host) FIFOs with levels, sticky errors and masked irq.
// Define PIO_FIFO_JOIN_EN to build shared 2*DEPTH storage per machine plus the join/flush logic.
module pio_fifo_hub #(
  parameter int NUM_MACHINES = 4,
  parameter int DEPTH        = 4,
  parameter int WIDTH        = 32,
  localparam int MIDX_W      = (NUM_MACHINES > 1) ? $clog2(NUM_MACHINES) : 1,
  localparam int LVL_W       = $clog2(2*DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [MIDX_W-1:0]             host_mindex,
  input  logic                          host_push,
  input  logic [WIDTH-1:0]              host_din,
  input  logic                          host_pull,
  output logic [WIDTH-1:0]              host_dout,
  output logic                          host_dout_valid,
  input  logic [NUM_MACHINES-1:0]       join_tx,
  input  logic [NUM_MACHINES-1:0]       join_rx,
  input  logic [NUM_MACHINES-1:0]       m_pull,
  output logic [NUM_MACHINES*WIDTH-1:0] m_dout,
  output logic [NUM_MACHINES-1:0]       m_empty,
  input  logic [NUM_MACHINES-1:0]       m_push,
  input  logic [NUM_MACHINES*WIDTH-1:0] m_din,
  output logic [NUM_MACHINES-1:0]       m_full,
  output logic [NUM_MACHINES-1:0]       tx_full,
  output logic [NUM_MACHINES-1:0]       rx_empty,
  output logic [NUM_MACHINES*LVL_W-1:0] tx_level,
  output logic [NUM_MACHINES*LVL_W-1:0] rx_level,
  output logic [4*NUM_MACHINES-1:0]     err,
  input  logic [4*NUM_MACHINES-1:0]     err_clr,
  input  logic [2*NUM_MACHINES-1:0]     irq_mask,
  output logic                          irq
);

  localparam int PTR_W = $clog2(2*DEPTH);
  localparam logic [LVL_W-1:0] CAP_1 = LVL_W'(DEPTH);

  logic [NUM_MACHINES-1:0] rx_pop_ok;
  logic [NUM_MACHINES-1:0] tx_src, rx_src;
  logic [WIDTH-1:0]        rx_head [NUM_MACHINES];
  logic [WIDTH-1:0]        host_dout_q, host_dout_d;
  logic                    valid_q, valid_d, irq_q, irq_d;

  // Pointers wrap at the effective capacity, which changes with join.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p, input logic [LVL_W-1:0] cap);
    logic [LVL_W-1:0] n;
    n = {1'b0, p} + LVL_W'(1);
    return (n >= cap) ? '0 : PTR_W'(n);
  endfunction

  for (genvar m = 0; m < NUM_MACHINES; m++) begin : g_m
    logic [LVL_W-1:0] tx_cap, rx_cap, tx_lvl_q, rx_lvl_q;
    logic [PTR_W-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic             tx_push, tx_pop, rx_push, rx_pop, flush;
    logic             tx_push_ok, tx_pop_ok, rx_push_ok;
    logic [3:0]       err_q, err_set;
    logic [WIDTH-1:0] tx_head;

    assign tx_push = host_push && (host_mindex == MIDX_W'(m));
    assign rx_pop  = host_pull && (host_mindex == MIDX_W'(m));
    assign tx_pop  = m_pull[m];
    assign rx_push = m_push[m];

    assign tx_push_ok   = tx_push && !flush && (tx_lvl_q < tx_cap);
    assign tx_pop_ok    = tx_pop  && !flush && (tx_lvl_q != '0);
    assign rx_push_ok   = rx_push && !flush && (rx_lvl_q < rx_cap);
    assign rx_pop_ok[m] = rx_pop  && !flush && (rx_lvl_q != '0);

    assign err_set = flush ? 4'b0000 :
                     {rx_pop && (rx_lvl_q == '0), rx_push && (rx_lvl_q >= rx_cap),
                      tx_pop && (tx_lvl_q == '0), tx_push && (tx_lvl_q >= tx_cap)};

`ifdef PIO_FIFO_JOIN_EN
    logic             jt_q, jr_q;
    logic [PTR_W-1:0] rx_wa, rx_ra;
    logic [WIDTH-1:0] mem_q [2*DEPTH];

    assign flush  = (join_tx[m] != jt_q) || (join_rx[m] != jr_q);
    assign tx_cap = jt_q ? LVL_W'(2*DEPTH) : (jr_q ? '0 : CAP_1);
    assign rx_cap = jt_q ? '0 : (jr_q ? LVL_W'(2*DEPTH) : CAP_1);
    // Unjoined RX lives in the upper half; joined RX owns the whole array.
    assign rx_wa  = (jr_q && !jt_q) ? rx_wp_q : {1'b1, rx_wp_q[PTR_W-2:0]};
    assign rx_ra  = (jr_q && !jt_q) ? rx_rp_q : {1'b1, rx_rp_q[PTR_W-2:0]};

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        jt_q <= 1'b0;
        jr_q <= 1'b0;
      end else begin
        jt_q <= join_tx[m];
        jr_q <= join_rx[m];
      end
    end

    always_ff @(posedge clk) begin
      if (tx_push_ok) mem_q[tx_wp_q] <= host_din;
      if (rx_push_ok) mem_q[rx_wa]   <= m_din[m*WIDTH +: WIDTH];
    end

    assign tx_head    = mem_q[tx_rp_q];
    assign rx_head[m] = mem_q[rx_ra];
`else
    logic [WIDTH-1:0] mem_tx_q [DEPTH];
    logic [WIDTH-1:0] mem_rx_q [DEPTH];

    assign flush  = 1'b0;
    assign tx_cap = CAP_1;
    assign rx_cap = CAP_1;

    always_ff @(posedge clk) begin
      if (tx_push_ok) mem_tx_q[tx_wp_q[PTR_W-2:0]] <= host_din;
      if (rx_push_ok) mem_rx_q[rx_wp_q[PTR_W-2:0]] <= m_din[m*WIDTH +: WIDTH];
    end

    assign tx_head    = mem_tx_q[tx_rp_q[PTR_W-2:0]];
    assign rx_head[m] = mem_rx_q[rx_rp_q[PTR_W-2:0]];
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        tx_lvl_q <= '0;
        rx_lvl_q <= '0;
        tx_wp_q  <= '0;
        tx_rp_q  <= '0;
        rx_wp_q  <= '0;
        rx_rp_q  <= '0;
        err_q    <= '0;
      end else begin
        err_q <= (err_q & ~err_clr[4*m +: 4]) | err_set;
        if (flush) begin
          tx_lvl_q <= '0;
          rx_lvl_q <= '0;
          tx_wp_q  <= '0;
          tx_rp_q  <= '0;
          rx_wp_q  <= '0;
          rx_rp_q  <= '0;
        end else begin
          if (tx_push_ok)   tx_wp_q <= ptr_inc(tx_wp_q, tx_cap);
          if (tx_pop_ok)    tx_rp_q <= ptr_inc(tx_rp_q, tx_cap);
          if (rx_push_ok)   rx_wp_q <= ptr_inc(rx_wp_q, rx_cap);
          if (rx_pop_ok[m]) rx_rp_q <= ptr_inc(rx_rp_q, rx_cap);
          tx_lvl_q <= tx_lvl_q + LVL_W'(tx_push_ok) - LVL_W'(tx_pop_ok);
          rx_lvl_q <= rx_lvl_q + LVL_W'(rx_push_ok) - LVL_W'(rx_pop_ok[m]);
        end
      end
    end

    assign m_dout[m*WIDTH +: WIDTH]   = tx_head;
    assign m_empty[m]                 = (tx_lvl_q == '0);
    assign tx_full[m]                 = (tx_lvl_q >= tx_cap);
    assign rx_empty[m]                = (rx_lvl_q == '0);
    assign m_full[m]                  = (rx_lvl_q >= rx_cap);
    assign tx_level[m*LVL_W +: LVL_W] = tx_lvl_q;
    assign rx_level[m*LVL_W +: LVL_W] = rx_lvl_q;
    assign err[4*m +: 4]              = err_q;
    assign tx_src[m]                  = (tx_lvl_q < tx_cap);
    assign rx_src[m]                  = (rx_lvl_q != '0);
  end

`ifndef PIO_FIFO_JOIN_EN
  logic unused_join;
  assign unused_join = ^{join_tx, join_rx};
`endif

  always_comb begin
    host_dout_d = host_dout_q;
    valid_d     = 1'b0;
    irq_d       = 1'b0;
    for (int m = 0; m < NUM_MACHINES; m++) begin
      if (rx_pop_ok[m]) begin
        host_dout_d = rx_head[m];
        valid_d     = 1'b1;
      end
      irq_d = irq_d | (irq_mask[2*m] & tx_src[m]) | (irq_mask[2*m+1] & rx_src[m]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_dout_q <= '0;
      valid_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      host_dout_q <= host_dout_d;
      valid_q     <= valid_d;
      irq_q       <= irq_d;
    end
  end

  assign host_dout       = host_dout_q;
  assign host_dout_valid = valid_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_pio_fifo_hub.sv
// Directed bench for pio_fifo_hub (default parameters) with scoreboard queues for TX and host-read data.
module tb_pio_fifo_hub;
  localparam int NM = 4;
  localparam int W  = 32;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            clk_en = 1'b1;
  logic            reset;
  logic [1:0]      host_mindex;
  logic            host_push, host_pull;
  logic [W-1:0]    host_din, host_dout;
  logic            host_dout_valid;
  logic [NM-1:0]   join_tx, join_rx, m_pull, m_empty, m_push, m_full, tx_full, rx_empty;
  logic [NM*W-1:0] m_dout, m_din;
  logic [NM*LW-1:0] tx_level, rx_level;
  logic [4*NM-1:0] err, err_clr;
  logic [2*NM-1:0] irq_mask;
  logic            irq;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] tx_sb[$];
  logic [W-1:0] rx_sb[$];
  logic [W-1:0] last_dout = '0;

  pio_fifo_hub dut (
    .clk(clk), .reset(reset), .host_mindex(host_mindex), .host_push(host_push),
    .host_din(host_din), .host_pull(host_pull), .host_dout(host_dout),
    .host_dout_valid(host_dout_valid), .join_tx(join_tx), .join_rx(join_rx),
    .m_pull(m_pull), .m_dout(m_dout), .m_empty(m_empty), .m_push(m_push), .m_din(m_din),
    .m_full(m_full), .tx_full(tx_full), .rx_empty(rx_empty), .tx_level(tx_level),
    .rx_level(rx_level), .err(err), .err_clr(err_clr), .irq_mask(irq_mask), .irq(irq)
  );

  always #5 clk = clk_en ? ~clk : clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hpush(input int m, input logic [W-1:0] d, input bit accepted);
    host_mindex = 2'(m);
    host_din    = d;
    host_push   = 1'b1;
    if (accepted) tx_sb.push_back(d);
    step();
    host_push = 1'b0;
  endtask

  task automatic mpull_chk(input int m);
    logic [W-1:0] e;
    e = tx_sb.pop_front();
    chk("m_dout", m_dout[m*W +: W], e);
    m_pull[m] = 1'b1;
    step();
    m_pull[m] = 1'b0;
  endtask

  task automatic mpush(input int m, input logic [W-1:0] d);
    m_din[m*W +: W] = d;
    m_push[m] = 1'b1;
    rx_sb.push_back(d);
    step();
    m_push[m] = 1'b0;
  endtask

  task automatic hpull_chk(input int m);
    host_mindex = 2'(m);
    host_pull   = 1'b1;
    step();
    host_pull   = 1'b0;
    if (rx_sb.size() > 0) begin
      last_dout = rx_sb.pop_front();
      chk("host_dout_valid", host_dout_valid, 1);
    end else begin
      chk("host_dout_valid_empty", host_dout_valid, 0);
    end
    chk("host_dout", host_dout, last_dout);
  endtask

  initial begin
    reset = 1'b1;
    host_mindex = '0; host_push = 0; host_pull = 0; host_din = '0;
    join_tx = '0; join_rx = '0; m_pull = '0; m_push = '0; m_din = '0;
    err_clr = '0; irq_mask = '0;
    #1;
    chk("rst_m_empty", m_empty, 4'hF);
    chk("rst_rx_empty", rx_empty, 4'hF);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_m_full", m_full, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_dout", host_dout, 0);
    chk("rst_valid", host_dout_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_irq", irq, 0);
    step(); step();
    reset = 1'b0;
    step();

    // Host fill of machine 1 then overflow, then machine drain.
    for (int i = 0; i < 4; i++) hpush(1, 32'hA0 + W'(i), 1'b1);
    chk("fill_level", tx_level[1*LW +: LW], 4);
    chk("fill_full", tx_full[1], 1);
    hpush(1, 32'hA4, 1'b0);
    chk("over_level", tx_level[1*LW +: LW], 4);
    chk("over_flag", err[4], 1);
    for (int i = 0; i < 4; i++) mpull_chk(1);
    chk("drain_empty", m_empty[1], 1);

    // Machine 0 fills RX, host reads past empty.
    mpush(0, 32'h11);
    mpush(0, 32'h22);
    chk("rx_level", rx_level[0 +: LW], 2);
    for (int i = 0; i < 3; i++) hpull_chk(0);
    chk("rx_under", err[3], 1);

    // Simultaneous push/pop on machine 2.
    hpush(2, 32'hB0, 1'b1);
    hpush(2, 32'hB1, 1'b1);
    chk("sim_head", m_dout[2*W +: W], tx_sb[0]);
    void'(tx_sb.pop_front());
    tx_sb.push_back(32'hB2);
    host_mindex = 2'd2; host_din = 32'hB2; host_push = 1; m_pull[2] = 1;
    step();
    host_push = 0; m_pull[2] = 0;
    chk("sim_level", tx_level[2*LW +: LW], 2);
    chk("sim_order", m_dout[2*W +: W], tx_sb[0]);
    hpush(2, 32'hB3, 1'b1);
    hpush(2, 32'hB4, 1'b1);
    chk("sim_full", tx_full[2], 1);
    chk("sim_head2", m_dout[2*W +: W], tx_sb[0]);
    void'(tx_sb.pop_front());
    host_mindex = 2'd2; host_din = 32'hB5; host_push = 1; m_pull[2] = 1;
    step();
    host_push = 0; m_pull[2] = 0;
    chk("full_pp_level", tx_level[2*LW +: LW], 3);
    chk("full_pp_over", err[8], 1);
    for (int i = 0; i < 3; i++) mpull_chk(2);
    chk("sim_empty", m_empty[2], 1);

    // RX-not-empty interrupt on machine 0 with one cycle of latency.
    irq_mask = 8'h02;
    step();
    chk("irq_idle", irq, 0);
    m_din[0 +: W] = 32'h33; m_push[0] = 1; rx_sb.push_back(32'h33);
    step();
    m_push[0] = 0;
    chk("irq_latency", irq, 0);
    step();
    chk("irq_set", irq, 1);
    hpull_chk(0);
    irq_mask = '0;

    // Write-one-to-clear, and set beating clear.
    err_clr[4] = 1'b1;
    step();
    err_clr[4] = 1'b0;
    chk("clr_bit", err[4], 0);
    chk("clr_other", err[3], 1);
    for (int i = 0; i < 4; i++) hpush(1, 32'hC0 + W'(i), 1'b1);
    err_clr[4] = 1'b1;
    hpush(1, 32'hC4, 1'b0);
    err_clr[4] = 1'b0;
    chk("set_beats_clr", err[4], 1);
    mpull_chk(1);
    mpull_chk(1);

`ifdef PIO_FIFO_JOIN_EN
    hpush(3, 32'hD0, 1'b1);
    hpush(3, 32'hD1, 1'b1);
    tx_sb.delete();
    join_tx[3] = 1'b1;
    step();
    chk("join_flush", tx_level[3*LW +: LW], 0);
    for (int i = 0; i < 8; i++) hpush(3, 32'hE0 + W'(i), 1'b1);
    chk("join_level", tx_level[3*LW +: LW], 8);
    chk("join_full", tx_full[3], 1);
    chk("join_rx_empty", rx_empty[3], 1);
    chk("join_m_full", m_full[3], 1);
    for (int i = 0; i < 8; i++) mpull_chk(3);
    join_tx[3] = 1'b0;
    step();
`endif

    // Async reset with the clock frozen.
    irq_mask = 8'h01;
    step();
    chk("irq_tx", irq, 1);
    #2;
    clk_en = 1'b0;
    host_mindex = 2'd1; host_din = 32'hFF; host_push = 1;
    #3;
    reset = 1'b1;
    #1;
    chk("arst_tx_level", tx_level, 0);
    chk("arst_m_empty", m_empty, 4'hF);
    chk("arst_rx_empty", rx_empty, 4'hF);
    chk("arst_tx_full", tx_full, 0);
    chk("arst_dout", host_dout, 0);
    chk("arst_err", err, 0);
    chk("arst_irq", irq, 0);
    #10;
    host_push = 0;
    irq_mask = '0;
    reset = 1'b0;
    clk_en = 1'b1;
    tx_sb.delete();
    step(); step();
    chk("post_tx_level", tx_level, 0);
    chk("post_rx_level", rx_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
